dm_sram_resp: RTL
=================

Name: dm_sram_resp

Overview:
- Data-memory responder: the far end of the MEM0 data-memory request interface.
- Accepts address, active-low byte enables, write data and read/write selects from the MEM0 stage.
- Performs byte-lane-masked writes into an internal synchronous SRAM array.
- Returns the full aligned read word one cycle later, in time for MEM1 to extract and sign-extend it.

Parameters:
- ADDR_W, 14, word-address bits; array depth 2^ADDR_W words (64 KiB at default).
- BASE_ADDR, 32'h0000_0000, byte base of the array; must be aligned to 2^(ADDR_W+2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dm_addr_i  input  32  byte address of the access.
- dm_be_n_i  input  4  active-low byte-lane enables; 4'b1111 = no access.
- dm_wdata_i  input  32  store data, right-justified (byte in [7:0], half in [15:0], word in [31:0]).
- dm_re_i  input  1  read request.
- dm_we_i  input  1  write request.
- dm_rdata_o  output  32  aligned read word at word address dm_addr_i[ADDR_W+1:2].
- dm_rvalid_o  output  1  one-cycle pulse: dm_rdata_o holds data for the previous cycle's read.
- dm_err_o  output  1  one-cycle pulse: the previous cycle's request was rejected.

Behaviour:
- Reset (async assert, sync deassert on the next edge):
  - dm_rdata_o=0, dm_rvalid_o=0, dm_err_o=0.
  - Array contents are not reset.
- Request qualification:
  - act = (dm_be_n_i != 4'b1111) && (dm_re_i || dm_we_i).
  - No act: no array change; rvalid=0 and err=0 next cycle; dm_rdata_o holds its last value.
- Legal be_n patterns:
  - byte: 1110, 1101, 1011, 0111.
  - half: 1100, 0011.
  - word: 0000.
- The request is rejected (err=1 next cycle, no write, rvalid=0, rdata held) when any of these holds:
  - act and the be_n pattern is illegal;
  - dm_re_i && dm_we_i both high;
  - dm_addr_i[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2] (out of range).
- Write (accepted act, we=1):
  - Commits at this rising edge to word addr = dm_addr_i[ADDR_W+1:2].
  - Lane steering:
    - byte: dm_wdata_i[7:0] is replicated to all four lanes.
    - half: dm_wdata_i[15:0] is replicated to both halves.
    - word: dm_wdata_i is passed unchanged.
  - Only lanes with be_n bit = 0 are written; other lanes are unchanged.
  - Next cycle: rvalid=0, err=0.
- Read (accepted act, re=1):
  - The array is read at this edge; dm_rdata_o = full aligned word and dm_rvalid_o=1 in the next cycle.
  - Latency is exactly 1 cycle.
  - be_n is used only for legality; it does not mask read data.
- Ordering:
  - Single port, so at most one access per cycle.
  - A write at cycle N followed by a read of the same word at N+1 returns the updated data at N+2. No bypass is needed because the write commits at edge N.
  - Back-to-back reads every cycle are supported, giving rvalid high continuously.
- Reset mid-operation: a pending read result is discarded (rvalid forced 0). A write whose edge has not yet occurred is not performed.
- Address wrap: none. Addresses outside the window raise an error and never alias.

Test Plan:
- SW word: we=1, be_n=0000, addr=0x10, wdata=0xDEADBEEF; next cycle read re=1, be_n=0000, addr=0x10 -> rvalid=1 and rdata=0xDEADBEEF one cycle after the read; err stays 0.
- SB lane steering: after word 0x00000000 at 0x20, SB addr=0x23, be_n=0111, wdata=0x000000AB; then read 0x20 -> rdata=0xAB000000.
- SH plus byte merge: word 0x11223344 at 0x30; SH addr=0x30, be_n=1100, wdata=0x0000BEEF -> rdata=0x1122BEEF. Then SB addr=0x31, be_n=1101, wdata=0x77 -> rdata=0x112277EF.
- Idle/hold: read 0x30 returns 0x11227 7EF; then 3 cycles of be_n=1111 with re=1 -> rvalid=0, err=0, rdata stays 0x112277EF, array unchanged.
- Error cases, each giving err=1 for exactly one cycle, rvalid=0, and no array change (verified by re-read):
  - be_n=1010 with re=1 -> rejected as illegal pattern.
  - re=1 and we=1 together -> rejected.
  - addr=0x0001_0000 with ADDR_W=14 -> rejected as out of range.
- Reset mid-read: issue a read at cycle N, assert rst_n=0 before edge N+1 -> rdata=0 and rvalid=0 throughout reset. After release, a re-read returns the pre-reset contents.

Source files
------------

// File: rtl/dm_sram_resp.sv
// dm_sram_resp: data-memory responder for the MEM0 request interface.
// Byte-lane-masked writes into a synchronous SRAM; full aligned read word one cycle later.
module dm_sram_resp #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dm_addr_i,
  input  logic [3:0]  dm_be_n_i,
  input  logic [31:0] dm_wdata_i,
  input  logic        dm_re_i,
  input  logic        dm_we_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_rvalid_o,
  output logic        dm_err_o
);
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_err;
  logic              w_act;
  logic              w_byte;
  logic              w_half;
  logic              w_word;
  logic              w_in_range;
  logic              w_err;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_wdata;
  logic              w_unused;
  assign w_act      = (dm_be_n_i != 4'b1111) && (dm_re_i || dm_we_i);
  assign w_byte     = dm_be_n_i inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  assign w_half     = dm_be_n_i inside {4'b1100, 4'b0011};
  assign w_word     = dm_be_n_i == 4'b0000;
  assign w_in_range = dm_addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign w_err      = w_act && (!(w_byte || w_half || w_word) || (dm_re_i && dm_we_i) || !w_in_range);
  assign w_rd       = w_act && !w_err && dm_re_i;
  assign w_wr       = w_act && !w_err && dm_we_i;
  assign w_idx      = dm_addr_i[ADDR_W+1:2];
  // Sub-word stores arrive right-justified; replicate so any enabled lane sees the data.
  assign w_wdata    = w_word ? dm_wdata_i : w_half ? {2{dm_wdata_i[15:0]}} : {4{dm_wdata_i[7:0]}};
  assign w_unused   = ^dm_addr_i[1:0];
  // Array has no reset; a write sampled while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (w_wr && rst_n)
      for (int b = 0; b < 4; b++)
        if (!dm_be_n_i[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= w_err;
      if (w_rd) r_rdata <= r_mem[w_idx];
    end
  end
  assign dm_rdata_o  = r_rdata;
  assign dm_rvalid_o = r_rvalid;
  assign dm_err_o    = r_err;
endmodule
